// File: rtl/serial_add_ctrl_pkg.sv
// Shared types for the bit-serial adder sequencer.
// Holds the controller state encoding used by the FSM and its decoders.
package serial_add_ctrl_pkg;

    // Encoding 2'd3 is unused and is treated as idle wherever it is decoded.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/done request bus between a requester and the serial adder sequencer.
// The sub signal exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADD_SUB_EN
    modport master (output start, a_in, b_in, cin, sub, input busy, done, sum, cout);
    modport slave  (input start, a_in, b_in, cin, sub, output busy, done, sum, cout);
`else
    modport master (output start, a_in, b_in, cin, input busy, done, sum, cout);
    modport slave  (input start, a_in, b_in, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/fa.sv
// Shared 1-bit full-adder cell, purely combinational.
module fa (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ c;
    assign cout = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell reused over WIDTH cycles, LSB first.
// Define SERIAL_ADD_SUB_EN to add the sub input (a - b via inverted b and forced carry-in).
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    serial_add_ctrl_if.slave bus
);

    localparam int unsigned    CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:1] s_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_s, fa_cout;
    logic [WIDTH-1:0] s_next;
    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             is_idle, accept, cnt_last;
    logic             busy, done;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction as a + ~b + 1; cout=1 then means no borrow.
    assign b_load = bus.sub ? ~bus.b_in : bus.b_in;
    assign c_load = bus.sub | bus.cin;
`else
    assign b_load = bus.b_in;
    assign c_load = bus.cin;
`endif

    assign is_idle  = (state_q != StRun) && (state_q != StDone);
    assign accept   = is_idle && bus.start;
    assign cnt_last = (cnt_q == CntLast);
    assign s_next   = {fa_s, s_q};

    fa u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .c    (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StRun;
            StRun:   if (cnt_last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = bus.start ? StRun : StIdle;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StRun:   busy = 1'b1;
            StDone: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.a_in;
            b_q     <= b_load;
            carry_q <= c_load;
            cnt_q   <= '0;
        end else if (state_q == StRun) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            carry_q <= fa_cout;
            s_q     <= s_next[WIDTH-1:1];
            // Counter holds at its last value so it never leaves 0..WIDTH-1.
            if (cnt_last) begin
                sum_q  <= s_next;
                cout_q <= fa_cout;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule
